// File: rtl/alu_pkg.sv
// Shared types and elaboration helpers for the chunked multi-cycle adder/subtractor.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic int chunkCount(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk build still needs a one-bit index register.
  function automatic int idxWidth(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple-carry slice; also exposes the carry into its MSB.
module adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] w_c;

  always_comb begin
    w_c    = '0;
    s      = '0;
    w_c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]     = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = w_c[CHUNK];
  assign c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/multicycle_add_sub.sv
// WIDTH-bit add/subtract computed CHUNK bits per clock through one shared slice.
// Optional signed-overflow flag is enabled by defining MULTICYCLE_ADD_SUB_OVF_EN.
module multicycle_add_sub
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N     = chunkCount(WIDTH, CHUNK);
  localparam int IDX_W = idxWidth(N);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || (WIDTH % CHUNK != 0)) begin : gParamCheck
    $error("multicycle_add_sub: WIDTH must be a positive multiple of CHUNK");
  end

  state_t             r_state;
  state_t             w_nextState;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic               r_cout;
  logic [31:0]        w_base;
  logic [CHUNK-1:0]   w_chunkS;
  logic               w_chunkCout;
  logic               w_chunkMsbC;
  logic               w_lastChunk;

  assign w_base      = 32'(r_idx) * 32'(CHUNK);
  assign w_lastChunk = (r_idx == IDX_W'(N - 1));

  adder_chunk #(.CHUNK(CHUNK)) u_adderChunk (
    .a    (r_a[w_base +: CHUNK]),
    .b    (r_b[w_base +: CHUNK]),
    .cin  (r_carry),
    .s    (w_chunkS),
    .cout (w_chunkCout),
    .c_msb(w_chunkMsbC)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_nextState = BUSY;
      end
      BUSY: begin
        if (w_lastChunk) w_nextState = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Subtraction is folded into the accept: B is inverted and cin becomes the borrow complement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if ((r_state == IDLE) && in_valid) begin
      r_a     <= a;
      r_b     <= b ^ {WIDTH{sub}};
      r_carry <= cin ^ sub;
      r_idx   <= '0;
      r_sum   <= '0;
    end else if (r_state == BUSY) begin
      r_sum[w_base +: CHUNK] <= w_chunkS;
      r_carry                <= w_chunkCout;
      if (w_lastChunk) r_cout <= w_chunkCout;
      else             r_idx  <= r_idx + IDX_W'(1);
    end
  end

`ifdef MULTICYCLE_ADD_SUB_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ovf <= 1'b0;
    else if ((r_state == BUSY) && w_lastChunk) r_ovf <= w_chunkMsbC ^ w_chunkCout;
  end

  assign ovf = r_ovf;
`else
  logic w_unusedMsbCarry;
  assign w_unusedMsbCarry = w_chunkMsbC;
  assign ovf              = 1'b0;
`endif

  assign sum  = r_sum;
  assign cout = r_cout;
  assign zero = (r_sum == '0);

endmodule

// File: tb/tb_multicycle_add_sub.sv
// Self-checking bench: directed vectors on the default build plus a parameter sweep.
module tb_multicycle_add_sub;

`ifdef MULTICYCLE_ADD_SUB_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid, inReady, subIn, cinIn, outValid, outReady;
  logic [31:0] aIn, bIn, sumOut;
  logic        coutOut, ovfOut, zeroOut;

  int   nChecks = 0;
  int   nFails  = 0;
  res_t expQ[$];

  always #5 clk = ~clk;

  multicycle_add_sub #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady),
    .a(aIn), .b(bIn), .sub(subIn), .cin(cinIn),
    .out_valid(outValid), .out_ready(outReady),
    .sum(sumOut), .cout(coutOut), .ovf(ovfOut), .zero(zeroOut)
  );

  // Sweep instances share operands and always accept results.
  logic        swValid, swSub, swCin;
  logic [31:0] swA, swB;
  logic [3:0]  swInReady, swOutValid, swCout, swOvf, swZero;
  logic [31:0] swSum0, swSum1, swSum2;
  logic [15:0] swSum16;

  multicycle_add_sub #(.WIDTH(32), .CHUNK(1)) dutC1 (
    .clk(clk), .rst_n(rstN), .in_valid(swValid), .in_ready(swInReady[0]),
    .a(swA), .b(swB), .sub(swSub), .cin(swCin),
    .out_valid(swOutValid[0]), .out_ready(1'b1),
    .sum(swSum0), .cout(swCout[0]), .ovf(swOvf[0]), .zero(swZero[0]));
  multicycle_add_sub #(.WIDTH(32), .CHUNK(4)) dutC4 (
    .clk(clk), .rst_n(rstN), .in_valid(swValid), .in_ready(swInReady[1]),
    .a(swA), .b(swB), .sub(swSub), .cin(swCin),
    .out_valid(swOutValid[1]), .out_ready(1'b1),
    .sum(swSum1), .cout(swCout[1]), .ovf(swOvf[1]), .zero(swZero[1]));
  multicycle_add_sub #(.WIDTH(32), .CHUNK(32)) dutC32 (
    .clk(clk), .rst_n(rstN), .in_valid(swValid), .in_ready(swInReady[2]),
    .a(swA), .b(swB), .sub(swSub), .cin(swCin),
    .out_valid(swOutValid[2]), .out_ready(1'b1),
    .sum(swSum2), .cout(swCout[2]), .ovf(swOvf[2]), .zero(swZero[2]));
  multicycle_add_sub #(.WIDTH(16), .CHUNK(4)) dutW16 (
    .clk(clk), .rst_n(rstN), .in_valid(swValid), .in_ready(swInReady[3]),
    .a(swA[15:0]), .b(swB[15:0]), .sub(swSub), .cin(swCin),
    .out_valid(swOutValid[3]), .out_ready(1'b1),
    .sum(swSum16), .cout(swCout[3]), .ovf(swOvf[3]), .zero(swZero[3]));

  // Reference arithmetic on plain integers, independent of chunking.
  function automatic res_t model(input logic [31:0] ia, input logic [31:0] ib,
                                 input logic isub, input logic icin, input int w);
    longint mask, half, ua, ub, sa, sb, full, sr, c;
    res_t   r;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(ia) & mask;
    ub   = longint'(ib) & mask;
    c    = longint'(icin);
    sa   = (ua >= half) ? ua - (mask + 1) : ua;
    sb   = (ub >= half) ? ub - (mask + 1) : ub;
    if (isub) begin
      full   = ua - ub - c;
      r.cout = (ua >= ub + c);
      sr     = sa - sb - c;
    end else begin
      full   = ua + ub + c;
      r.cout = ((full >> w) & 1) != 0;
      sr     = sa + sb + c;
    end
    r.sum  = 32'(full & mask);
    r.ovf  = OVF_ON && ((sr >= half) || (sr < -half));
    r.zero = (r.sum == 32'd0);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare the main DUT against the model every cycle its result is presented.
  always @(negedge clk) begin
    if (rstN && outValid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected out_valid", 64'(outValid), 64'(0));
      end else begin
        checkOutput("model sum",  64'(sumOut),  64'(expQ[0].sum));
        checkOutput("model cout", 64'(coutOut), 64'(expQ[0].cout));
        checkOutput("model ovf",  64'(ovfOut),  64'(expQ[0].ovf));
        checkOutput("model zero", 64'(zeroOut), 64'(expQ[0].zero));
        if (outReady) void'(expQ.pop_front());
      end
    end
    if (rstN && inValid && inReady) expQ.push_back(model(aIn, bIn, subIn, cinIn, 32));
  end

  always @(negedge rstN) expQ.delete();

  task automatic applyStimulus(input logic [31:0] ia, input logic [31:0] ib,
                               input logic isub, input logic icin, input int hold,
                               input logic [31:0] expSum, input logic expCout,
                               input logic expOvf, input logic expZero);
    int lat;
    aIn = ia; bIn = ib; subIn = isub; cinIn = icin;
    inValid = 1'b1; outReady = 1'b0;
    checkOutput("in_ready before accept", 64'(inReady), 64'(1));
    @(posedge clk); #1;
    inValid = 1'b0;
    aIn = $urandom; bIn = $urandom; subIn = ~isub; cinIn = ~icin;
    lat = 0;
    while (!outValid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", 64'(lat), 64'(4));
    checkOutput("sum literal",  64'(sumOut),  64'(expSum));
    checkOutput("cout literal", 64'(coutOut), 64'(expCout));
    checkOutput("ovf literal",  64'(ovfOut),  64'(expOvf));
    checkOutput("zero literal", 64'(zeroOut), 64'(expZero));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput("in_ready held low", 64'(inReady), 64'(0));
      checkOutput("out_valid held",    64'(outValid), 64'(1));
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    checkOutput("idle in_ready", 64'(inReady), 64'(1));
    checkOutput("idle out_valid", 64'(outValid), 64'(0));
  endtask

  task automatic sweepRun(input int iters);
    int   expLat[4] = '{32, 8, 1, 4};
    int   widthOf[4] = '{32, 32, 32, 16};
    logic done[4];
    int   cyc;
    res_t e;
    logic [31:0] got;
    for (int it = 0; it < iters; it++) begin
      swA = $urandom; swB = $urandom;
      swSub = 1'($urandom_range(0, 1)); swCin = 1'($urandom_range(0, 1));
      swValid = 1'b1;
      for (int i = 0; i < 4; i++) done[i] = 1'b0;
      @(posedge clk); #1;
      swValid = 1'b0;
      cyc = 0;
      while (!(done[0] && done[1] && done[2] && done[3]) && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
          if (!done[i] && swOutValid[i]) begin
            done[i] = 1'b1;
            e = model(swA, swB, swSub, swCin, widthOf[i]);
            got = (i == 0) ? swSum0 : (i == 1) ? swSum1 : (i == 2) ? swSum2 : {16'h0, swSum16};
            checkOutput($sformatf("sweep%0d latency", i), 64'(cyc), 64'(expLat[i]));
            checkOutput($sformatf("sweep%0d sum", i),  64'(got),       64'(e.sum));
            checkOutput($sformatf("sweep%0d cout", i), 64'(swCout[i]), 64'(e.cout));
            checkOutput($sformatf("sweep%0d ovf", i),  64'(swOvf[i]),  64'(e.ovf));
            checkOutput($sformatf("sweep%0d zero", i), 64'(swZero[i]), 64'(e.zero));
          end
        end
      end
      for (int i = 0; i < 4; i++)
        if (!done[i]) checkOutput($sformatf("sweep%0d timeout", i), 64'(0), 64'(1));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rstN = 1'b0; inValid = 1'b0; outReady = 1'b0;
    aIn = '0; bIn = '0; subIn = 1'b0; cinIn = 1'b0;
    swValid = 1'b0; swA = '0; swB = '0; swSub = 1'b0; swCin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready",  64'(inReady),  64'(1));
    checkOutput("reset out_valid", 64'(outValid), 64'(0));
    checkOutput("reset sum",       64'(sumOut),   64'(0));
    checkOutput("reset cout",      64'(coutOut),  64'(0));
    checkOutput("reset ovf",       64'(ovfOut),   64'(0));
    checkOutput("reset zero",      64'(zeroOut),  64'(1));
    rstN = 1'b1;
    @(posedge clk); #1;

    applyStimulus(32'h18000441, 32'h18642201, 1'b0, 1'b0, 0, 32'h30642642, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h1800044D, 32'h18642205, 1'b0, 1'b0, 5, 32'h30642652, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'd5, 32'd7, 1'b1, 1'b0, 0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'd5, 32'd7, 1'b1, 1'b1, 0, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 1, 32'h80000000, 1'b0, OVF_ON, 1'b0);
    applyStimulus(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 0, 32'h00000000, 1'b1, 1'b0, 1'b1);

    // Abort an operation two cycles after it was accepted.
    aIn = 32'hFFFFFFFF; bIn = 32'hFFFFFFFF; subIn = 1'b0; cinIn = 1'b1; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b0;
    #1;
    checkOutput("midbusy in_ready",  64'(inReady),  64'(1));
    checkOutput("midbusy out_valid", 64'(outValid), 64'(0));
    checkOutput("midbusy sum",       64'(sumOut),   64'(0));
    checkOutput("midbusy cout",      64'(coutOut),  64'(0));
    checkOutput("midbusy zero",      64'(zeroOut),  64'(1));
    @(posedge clk); #1;
    rstN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checkOutput("no out_valid after abort", 64'(outValid), 64'(0));
    end
    applyStimulus(32'h12345678, 32'h11111111, 1'b1, 1'b0, 2, 32'h01234567, 1'b1, 1'b0, 1'b0);

    sweepRun(1000);
    checkOutput("model queue drained", 64'(expQ.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/multicycle_add_sub.md
# multicycle_add_sub

Parametrised multi-cycle adder/subtractor for the 32-bit MIPS datapath and its multi-cycle execution units. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock through one shared CHUNK-bit carry-propagate slice, trading latency for area. It exposes a valid/ready handshake on both sides and reports carry, signed overflow and zero flags. It generalises the fixed 32-bit combinational adder with width, chunking, subtract mode, carry-in and flags.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 = A+B+cin, 1 = A−B−cin (cin is borrow-in).
- cin  in  1  carry/borrow in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry-out of MSB; for sub, 1 means no borrow.
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  sum == 0.

## Operation
- FSM states IDLE, BUSY, DONE. Reset enters IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b ^ {WIDTH{sub}}, and carry = cin ^ sub. Clear chunk index and result. Go to BUSY.
- BUSY: in_ready=0. Each cycle add chunk[idx] of A and B' with the carry register. Write the CHUNK-bit result into sum[idx*CHUNK +: CHUNK] and update carry. When idx == WIDTH/CHUNK−1, capture cout and ovf and go to DONE.
- ovf = carry into MSB XOR carry out of MSB, taken from the last chunk.
- zero is computed combinationally from the registered sum. It is meaningful only while out_valid=1.
- DONE: out_valid=1. sum and flags are held stable until out_ready. On out_valid&&out_ready, go to IDLE.
- Input changes outside the accept cycle are ignored, because operands are latched.
- No overlap: a new accept is possible only in IDLE.

## Timing
- Reset values:
  - in_ready=1, out_valid=0
  - sum=0, cout=0, ovf=0, zero=1
  - state=IDLE, chunk index=0, carry=0
- Latency: operands accepted at edge k → out_valid=1 after edge k+WIDTH/CHUNK.
  - Default parameters: 4 cycles.
  - CHUNK==WIDTH: 1 cycle.
- Throughput: one operation per WIDTH/CHUNK+2 cycles minimum (accept edge, BUSY cycles, DONE handshake edge).
- out_ready may be held high continuously; DONE still lasts at least one cycle.
- After the DONE handshake edge, in_ready is 1 in the next cycle.
- Reset asserted mid-BUSY or mid-DONE:
  - return immediately to reset values;
  - discard the partial result;
  - issue no out_valid pulse.
- out_ready while not in DONE is ignored.
- in_valid while not in IDLE is ignored and not queued.

## Configuration
- MULTICYCLE_ADD_SUB_OVF_EN defined:
  - ovf computed as above;
  - the MSB carry-in is captured in the final BUSY cycle.
- MULTICYCLE_ADD_SUB_OVF_EN undefined:
  - ovf tied to 0;
  - no overflow capture logic;
  - the port remains present for interface stability.

## Structure
- Package alu_pkg holds:
  - the state enum (IDLE, BUSY, DONE);
  - a localparam function for chunk count (WIDTH/CHUNK);
  - chunk-index width via $clog2.
- Sub-module adder_chunk: combinational CHUNK-bit ripple adder.
  - Inputs: a, b, cin.
  - Outputs: s, cout, and carry into its MSB (used for ovf).
  - Instantiated once.
- Elaboration-time check: WIDTH % CHUNK == 0, else $error.

## Test plan
- Add: a=0x18000441, b=0x18642201, sub=0, cin=0 → sum=0x30642642, cout=0, ovf=0, zero=0; out_valid exactly 4 cycles after accept.
- Add then backpressure: a=0x1800044D, b=0x18642205 → sum=0x30642652. Hold out_ready=0 for 5 cycles → out_valid and sum stay stable and in_ready stays 0. Assert out_ready → IDLE next cycle.
- Subtract: a=5, b=7, sub=1, cin=0 → sum=0xFFFFFFFE, cout=0, ovf=0. With cin=1 → sum=0xFFFFFFFD.
- Flags, two operations:
  - a=0x7FFFFFFF, b=1 → sum=0x80000000, ovf=1 (0 without MULTICYCLE_ADD_SUB_OVF_EN), cout=0.
  - a=0xFFFFFFFF, b=1 → sum=0, cout=1, zero=1, ovf=0.
- Reset mid-BUSY: assert rst_n=0 two cycles after accept → outputs at reset values immediately, no out_valid. A new operation after release completes correctly.
- Parameter sweep: WIDTH=32 with CHUNK ∈ {1, 4, 32}, and WIDTH=16 with CHUNK=4, on 1000 random operands against a reference model → sums and flags match; latency equals WIDTH/CHUNK.
